seq_signed_divider: RTL and testbench

- Multi-cycle signed integer divider; sits directly downstream of the arithmetic-shift stage in the arithmetic datapath and replaces it for general divisors.
- Quotient truncates toward zero (C / Verilog `/` semantics); remainder takes the sign of the dividend.
- Positive power-of-two divisors take a 1-cycle fast path: arithmetic right shift plus negative-dividend bias correction, so `-7/4 = -1`, not `-2`.
- Other divisors take an N-iteration restoring path. Valid/ready handshake on input and output.

---
 rtl/seq_signed_divider_pkg.sv | 36 +++
 rtl/seq_signed_divider_pow2.sv | 30 +++
 rtl/seq_signed_divider.sv | 182 ++++++++++++++++++
 tb/tb_seq_signed_divider.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_signed_divider_pkg.sv
// Shared types and helpers for the sequential signed divider.
//   state_e  : controller states (IDLE, CALC, DONE)
//   pow2_t   : result of the power-of-two divisor test (valid bit + shift amount)
//   is_pow2  : detects a positive divisor 2^k with 0 <= k <= n-2
package seq_signed_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Shift amounts are carried at a fixed width so the helper works for any
  // operand width up to 64 bits.
  localparam int K_W = 6;

  typedef struct packed {
    logic           valid;
    logic [K_W-1:0] k;
  } pow2_t;

  // v is the divisor zero-extended to 64 bits and n its real width. The sign
  // bit position (n-1) is excluded, so negative divisors never qualify.
  function automatic pow2_t is_pow2(input logic [63:0] v, input int n);
    pow2_t res;
    res = '0;
    for (int i = 0; i < 64; i++) begin
      if ((i <= n - 2) && (v == (64'd1 << i))) begin
        res.valid = 1'b1;
        res.k     = K_W'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_signed_divider_pow2.sv
// Combinational fast path: signed division by 2^k with truncation toward zero.
//   a : signed dividend (N bits)
//   k : shift amount, 0 <= k <= N-2
//   q : a / 2^k, truncated toward zero
//   r : a - q * 2^k (takes the sign of a)
module signed_div_pow2_trunc
  import seq_signed_divider_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]   a,
  input  logic [K_W-1:0] k,
  output logic [N-1:0]   q,
  output logic [N-1:0]   r
);

  logic [N:0]        bias;
  logic signed [N:0] sum;

  // A plain arithmetic shift rounds toward -inf; adding 2^k-1 to negative
  // dividends first turns that into truncation toward zero. One extra bit
  // keeps the biased sum from wrapping for the most negative dividend.
  always_comb begin
    bias = a[N-1] ? (((N+1)'(1) << k) - (N+1)'(1)) : '0;
    sum  = $signed({a[N-1], a}) + $signed(bias);
    q    = N'(sum >>> k);
    r    = a - (q << k);
  end

endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed integer divider (C-style truncating quotient, remainder
// carries the sign of the dividend).
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : operand handshake (dividend, divisor)
//   out_valid/out_ready   : result handshake (quotient, remainder, flags)
//   div_by_zero, overflow : qualify the result, valid with out_valid
//   dbg_state             : current controller state for observation
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 only in IDLE; out_valid is 1 only in DONE, and the
// result is held unchanged there until out_ready is seen at an edge.
//
// Zero divisor, overflow and positive power-of-two divisors finish at the
// accepting edge. All others run N restoring steps in CALC, the last step
// also applying the signs, so the result appears N+1 edges after accept.
module seq_signed_divider
  import seq_signed_divider_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero,
  output logic         overflow,
  output state_e       dbg_state
);

  localparam int          CW      = $clog2(N);
  localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

  state_e         state_q, state_d;
  logic [N-1:0]   dvd_q, dvd_d;       // dividend magnitude; quotient bits shift in at the LSB
  logic [N-1:0]   dvs_q, dvs_d;       // divisor magnitude
  logic [N-1:0]   rem_q, rem_d;       // partial remainder, always < |divisor|
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           q_neg_q, q_neg_d;
  logic           r_neg_q, r_neg_d;
  logic [N-1:0]   quotient_q, quotient_d;
  logic [N-1:0]   remainder_q, remainder_d;
  logic           dbz_q, dbz_d;
  logic           ovf_q, ovf_d;

  function automatic logic [N-1:0] magnitude(input logic [N-1:0] v);
    return v[N-1] ? (N'(0) - v) : v;
  endfunction

  // Fast path, evaluated on the live input operands.
  pow2_t        pow2;
  logic [N-1:0] fast_q, fast_r;
  logic         is_ovf;

  assign pow2   = is_pow2({{(64-N){1'b0}}, divisor}, N);
  assign is_ovf = (dividend == MIN_VAL) && (divisor == '1);

  signed_div_pow2_trunc #(.N(N)) u_pow2 (
    .a (dividend),
    .k (pow2.k),
    .q (fast_q),
    .r (fast_r)
  );

  // One restoring step. rem_shift is N+1 bits wide; the subtraction borrow
  // (trial[N]) decides whether the trial difference is kept.
  logic [N:0]   rem_shift, trial;
  logic         qbit;
  logic [N-1:0] q_mag, r_mag;

  always_comb begin
    rem_shift = {rem_q, dvd_q[N-1]};
    trial     = rem_shift - {1'b0, dvs_q};
    qbit      = ~trial[N];
    q_mag     = {dvd_q[N-2:0], qbit};
    r_mag     = qbit ? trial[N-1:0] : rem_shift[N-1:0];
  end

  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = DONE;
          if (divisor == '0) begin
            dbz_d       = 1'b1;
            quotient_d  = '1;
            remainder_d = dividend;
          end else if (is_ovf) begin
            ovf_d       = 1'b1;
            quotient_d  = MIN_VAL;
            remainder_d = '0;
          end else if (pow2.valid) begin
            quotient_d  = fast_q;
            remainder_d = fast_r;
          end else begin
            dvd_d   = magnitude(dividend);
            dvs_d   = magnitude(divisor);
            rem_d   = '0;
            cnt_d   = '0;
            q_neg_d = dividend[N-1] ^ divisor[N-1];
            r_neg_d = dividend[N-1];
            state_d = CALC;
          end
        end
      end
      CALC: begin
        dvd_d = q_mag;
        rem_d = r_mag;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          quotient_d  = q_neg_q ? (N'(0) - q_mag) : q_mag;
          remainder_d = r_neg_q ? (N'(0) - r_mag) : r_mag;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider at N = 8.
module tb_seq_signed_divider;
  import seq_signed_divider_pkg::*;

  localparam int N = 8;
  localparam int W = 2 * N + 2;   // {quotient, remainder, div_by_zero, overflow}

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;
  state_e       dbg_state;

  always #5 clk = ~clk;

  seq_signed_divider #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_compared   = 0;
  int n_mismatched = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model built on the simulator's own signed / and %.
  function automatic logic [W-1:0] ref_div(input logic [N-1:0] a, input logic [N-1:0] b);
    int sa, sb, q, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (b == '0) return {8'hff, a, 1'b1, 1'b0};
    if (a == 8'h80 && b == 8'hff) return {8'h80, 8'h00, 1'b0, 1'b1};
    q = sa / sb;
    r = sa % sb;
    return {q[N-1:0], r[N-1:0], 2'b00};
  endfunction

  function automatic int ref_lat(input logic [N-1:0] a, input logic [N-1:0] b);
    if (b == '0) return 1;
    if (a == 8'h80 && b == 8'hff) return 1;
    for (int k = 0; k <= N - 2; k++) begin
      if (int'(b) == (1 << k)) return 1;
    end
    return N + 1;
  endfunction

  function automatic logic [N-1:0] pick_operand();
    logic [N-1:0] specials [10];
    specials = '{8'h80, 8'hff, 8'h00, 8'h01, 8'h02, 8'h04, 8'h40, 8'h7f, 8'h81, 8'h08};
    if ($urandom_range(0, 2) == 0) return specials[$urandom_range(0, 9)];
    return N'($urandom_range(0, 255));
  endfunction

  // ---------------- driver ----------------
  // Issues one operation, measures latency (accepting edge counts as 1),
  // optionally holds off out_ready for `hold` cycles, then consumes it.
  // With noise set, in_valid/operands/out_ready are wiggled while the
  // divider is busy; none of that may disturb the result.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [W-1:0] exp_w, input int exp_lat,
                        input int hold, input bit noise);
    int           lat;
    int           waitc;
    logic [W-1:0] exp;
    logic [W-1:0] got;
    @(negedge clk);
    waitc = 0;
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    check_val("in_ready_before_issue", 32'(in_ready), 32'd1);
    exp_q.push_back(exp_w);
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      if (noise) begin
        in_valid  = 1'($urandom_range(0, 1));
        dividend  = N'($urandom_range(0, 255));
        divisor   = N'($urandom_range(0, 255));
        out_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      lat++;
    end
    out_ready = 1'b0;
    check_val("latency", 32'(lat), 32'(exp_lat));
    check_val("out_valid", 32'(out_valid), 32'd1);
    check_val("in_ready_in_done", 32'(in_ready), 32'd0);
    if (exp_q.size() == 0) begin
      check_val("scoreboard_empty", 32'd0, 32'd1);
      exp = '0;
    end else begin
      exp = exp_q.pop_front();
    end
    got = {quotient, remainder, div_by_zero, overflow};
    check_val("quotient", 32'(quotient), 32'(exp[W-1 -: N]));
    check_val("remainder", 32'(remainder), 32'(exp[W-N-1 -: N]));
    check_val("div_by_zero", 32'(div_by_zero), 32'(exp[1]));
    check_val("overflow", 32'(overflow), 32'(exp[0]));
    for (int h = 0; h < hold; h++) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        dividend = N'($urandom_range(0, 255));
        divisor  = N'($urandom_range(0, 255));
      end
      @(negedge clk);
      check_val("hold_out_valid", 32'(out_valid), 32'd1);
      check_val("hold_in_ready", 32'(in_ready), 32'd0);
      check_val("hold_result", 32'({quotient, remainder, div_by_zero, overflow}), 32'(got));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_val("released_out_valid", 32'(out_valid), 32'd0);
    check_val("released_in_ready", 32'(in_ready), 32'd1);
  endtask

  // ---------------- directed vectors (hand-computed) ----------------
  logic [N-1:0] v_a   [13] = '{8'hf9, 8'd100, 8'h9c, 8'h80, 8'd5, 8'h80, 8'd127,
                               8'h80, 8'h80, 8'd7, 8'hff, 8'h80, 8'hfb};
  logic [N-1:0] v_b   [13] = '{8'd4, 8'd7, 8'd7, 8'hff, 8'd0, 8'd64, 8'hfd,
                               8'd3, 8'h80, 8'h80, 8'd2, 8'd1, 8'hff};
  logic [N-1:0] v_q   [13] = '{8'hff, 8'h0e, 8'hf2, 8'h80, 8'hff, 8'hfe, 8'hd6,
                               8'hd6, 8'h01, 8'h00, 8'h00, 8'h80, 8'h05};
  logic [N-1:0] v_r   [13] = '{8'hfd, 8'h02, 8'hfe, 8'h00, 8'h05, 8'h00, 8'h01,
                               8'hfe, 8'h00, 8'h07, 8'hff, 8'h00, 8'h00};
  logic         v_dbz [13] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
  logic         v_ovf [13] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int           v_lat [13] = '{1, 9, 9, 1, 1, 1, 9, 9, 9, 9, 1, 1, 9};
  int           v_hold[13] = '{0, 5, 1, 0, 2, 0, 0, 1, 0, 0, 3, 0, 0};

  initial begin
    logic [N-1:0] ra, rb;

    // Reset state while rst_n is low.
    #12;
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_quotient", 32'(quotient), 32'd0);
    check_val("rst_remainder", 32'(remainder), 32'd0);
    check_val("rst_flags", 32'({div_by_zero, overflow}), 32'd0);
    check_val("rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      run_op(v_a[i], v_b[i], {v_q[i], v_r[i], v_dbz[i], v_ovf[i]}, v_lat[i], v_hold[i], 1'b0);
    end

    // Reset in the middle of a long division: previous result (5) is still
    // on the outputs, and must be cleared asynchronously.
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 8'd7;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_val("calc_state", 32'(dbg_state), 32'(CALC));
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_out_valid", 32'(out_valid), 32'd0);
    check_val("midrst_quotient", 32'(quotient), 32'd0);
    check_val("midrst_remainder", 32'(remainder), 32'd0);
    check_val("midrst_flags", 32'({div_by_zero, overflow}), 32'd0);
    check_val("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_val("post_rst_no_result", 32'(out_valid), 32'd0);
    end
    check_val("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Mixed operands with random handshake activity, checked against the model.
    for (int i = 0; i < 2000; i++) begin
      ra = pick_operand();
      rb = pick_operand();
      run_op(ra, rb, ref_div(ra, rb), ref_lat(ra, rb), $urandom_range(0, 3), 1'b1);
    end

    check_val("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
